// File: rtl/out_channel_checker_if.sv
// Output channel of the test core: producer drives valid/data, the checker drives ready.
interface out_channel_checker_if #(
  parameter int MemoryElementWidth = 12
) ();
  logic                          out_valid;
  logic [MemoryElementWidth-1:0] out_data;
  logic                          out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/out_channel_checker.sv
// Judges the out-channel word stream against a preloaded expected table and
// reports finished/success, with a RUN-state timeout for stalled programs.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 1,
  parameter int TimeoutCycles      = 1000,
  parameter int CountWidth         = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          exp_we,
  input  logic [CountWidth-1:0]         exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          start,
  out_channel_checker_if.slave          out_ch,
  output logic                          finished,
  output logic                          success,
  output logic [CountWidth-1:0]         received,
  output logic [CountWidth-1:0]         first_bad
);

  localparam int Depth     = (NOut > 0) ? NOut : 1;
  localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CountWidth-1:0] LastIdx   = (NOut > 0) ? CountWidth'(NOut - 1) : '0;
  localparam logic [CountWidth-1:0] TimerLast = CountWidth'(TimeoutCycles - 1);
  localparam logic [CountWidth-1:0] NOutCount = CountWidth'(NOut);
  localparam logic [CountWidth-1:0] AllOnes   = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    out_ready_q, out_ready_d;
  logic                    finished_q, finished_d;
  logic                    success_q, success_d;
  logic                    bad_q, bad_d;
  logic [CountWidth-1:0]   received_q, received_d;
  logic [CountWidth-1:0]   first_bad_q, first_bad_d;
  logic [CountWidth-1:0]   timer_q, timer_d;

  // Reset asserts immediately but releases only after two clock edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // Expected table is deliberately left out of reset so it survives a restart.
  logic [MemoryElementWidth-1:0] table_mem [Depth];
  logic                          table_we;
  logic [AddrWidth-1:0]          wr_idx;
  logic [AddrWidth-1:0]          rd_idx;
  logic [MemoryElementWidth-1:0] rd_data;

  assign table_we = exp_we && (state_q == IDLE) && (exp_addr < NOutCount);
  assign wr_idx   = exp_addr[AddrWidth-1:0];
  assign rd_idx   = received_q[AddrWidth-1:0];
  assign rd_data  = table_mem[rd_idx];

  always_ff @(posedge clock) begin
    if (table_we) begin
      table_mem[wr_idx] <= exp_data;
    end
  end

  logic transfer;
  logic mismatch;

  assign transfer = out_ch.out_valid && out_ready_q;
  assign mismatch = (out_ch.out_data != rd_data);

  always_comb begin
    state_d     = state_q;
    out_ready_d = out_ready_q;
    finished_d  = finished_q;
    success_d   = success_q;
    bad_d       = bad_q;
    received_d  = received_q;
    first_bad_d = first_bad_q;
    timer_d     = timer_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          out_ready_d = 1'b1;
          received_d  = '0;
          first_bad_d = AllOnes;
          bad_d       = 1'b0;
          timer_d     = '0;
          if (NOut == 0) begin
            state_d    = DONE;
            finished_d = 1'b1;
            success_d  = 1'b1;
          end else begin
            state_d    = RUN;
            finished_d = 1'b0;
            success_d  = 1'b0;
          end
        end else if (state_q == DONE && transfer) begin
          // Anything after the last expected word is an overflow.
          success_d  = 1'b0;
          received_d = (received_q == AllOnes) ? received_q : received_q + 1'b1;
        end
      end

      RUN: begin
        if (transfer) begin
          if (mismatch) begin
            bad_d = 1'b1;
            if (first_bad_q == AllOnes) begin
              first_bad_d = received_q;
            end
          end
          received_d = received_q + 1'b1;
        end
        // A final transfer on the expiry edge takes priority over the timeout.
        if (transfer && received_q == LastIdx) begin
          state_d    = DONE;
          finished_d = 1'b1;
          success_d  = !(bad_q || mismatch);
        end else if (timer_q == TimerLast) begin
          state_d    = DONE;
          finished_d = 1'b1;
          success_d  = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      out_ready_q <= 1'b0;
      finished_q  <= 1'b0;
      success_q   <= 1'b0;
      bad_q       <= 1'b0;
      received_q  <= '0;
      first_bad_q <= AllOnes;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_ready_q <= out_ready_d;
      finished_q  <= finished_d;
      success_q   <= success_d;
      bad_q       <= bad_d;
      received_q  <= received_d;
      first_bad_q <= first_bad_d;
      timer_q     <= timer_d;
    end
  end

  assign out_ch.out_ready = out_ready_q;
  assign finished         = finished_q;
  assign success          = success_q;
  assign received         = received_q;
  assign first_bad        = first_bad_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed and randomized checks of out_channel_checker across four table sizes
// (NOut = 3, 1, 4, 0), judged against outcomes computed from the channel rules.
module tb_out_channel_checker;

  localparam int MW = 12;
  localparam int CW = 16;
  localparam logic [31:0] NONE = 32'h0000_FFFF;

  function automatic int nout_of(input int i);
    case (i)
      0: return 3;
      1: return 1;
      2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int timeout_of(input int i);
    return (i == 1 || i == 3) ? 8 : 64;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          we_s       [4];
  logic [CW-1:0] addr_s     [4];
  logic [MW-1:0] wdata_s    [4];
  logic          start_s    [4];
  logic          valid_s    [4];
  logic [MW-1:0] data_s     [4];
  logic          ready_s    [4];
  logic          finished_s [4];
  logic          success_s  [4];
  logic [CW-1:0] received_s [4];
  logic [CW-1:0] first_bad_s[4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    out_channel_checker_if #(.MemoryElementWidth(MW)) ch ();
    assign ch.out_valid = valid_s[gi];
    assign ch.out_data  = data_s[gi];
    assign ready_s[gi]  = ch.out_ready;

    out_channel_checker #(
      .MemoryElementWidth(MW),
      .NOut(nout_of(gi)),
      .TimeoutCycles(timeout_of(gi)),
      .CountWidth(CW)
    ) dut (
      .clock    (clk),
      .reset    (rst_n),
      .exp_we   (we_s[gi]),
      .exp_addr (addr_s[gi]),
      .exp_data (wdata_s[gi]),
      .start    (start_s[gi]),
      .out_ch   (ch.slave),
      .finished (finished_s[gi]),
      .success  (success_s[gi]),
      .received (received_s[gi]),
      .first_bad(first_bad_s[gi])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input int d, input string tag, input logic fin, input logic suc,
                              input int rcv, input logic [31:0] fb);
    check($sformatf("%s.finished[%0d]", tag, d), 32'(finished_s[d]), 32'(fin));
    check($sformatf("%s.success[%0d]", tag, d), 32'(success_s[d]), 32'(suc));
    check($sformatf("%s.received[%0d]", tag, d), 32'(received_s[d]), 32'(rcv));
    check($sformatf("%s.first_bad[%0d]", tag, d), 32'(first_bad_s[d]), fb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input int a, input int v);
    we_s[d]    = 1'b1;
    addr_s[d]  = CW'(a);
    wdata_s[d] = MW'(v);
    tick();
    we_s[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic send(input int d, input int v, input int gap);
    valid_s[d] = 1'b1;
    data_s[d]  = MW'(v);
    $display("xfer dut=%0d data=0x%0h ready=%0b", d, v, ready_s[d]);
    tick();
    valid_s[d] = 1'b0;
    repeat (gap) tick();
  endtask

  int tbl[4];
  int n, w, fb;
  bit bad;

  initial begin
    for (int i = 0; i < 4; i++) begin
      we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
      start_s[i] = 1'b0; valid_s[i] = 1'b0; data_s[i] = '0;
    end
    repeat (2) tick();
    check("reset.ready", 32'(ready_s[2]), 32'd0);
    check_status(2, "reset", 1'b0, 1'b0, 0, NONE);
    rst_n = 1'b1;
    repeat (4) tick();

    load(0, 0, 2); load(0, 1, 5); load(0, 2, 7);
    load(1, 0, 2);
    load(2, 0, 11); load(2, 1, 22); load(2, 2, 33); load(2, 3, 44);

    // NOut=3, matching stream back-to-back
    pulse_start(0);
    check("t1.ready", 32'(ready_s[0]), 32'd1);
    send(0, 2, 0); send(0, 5, 0);
    check_status(0, "t1.mid", 1'b0, 1'b0, 2, NONE);
    send(0, 7, 0);
    check_status(0, "t1.end", 1'b1, 1'b1, 3, NONE);

    // NOut=3, one bad word with gaps
    pulse_start(0);
    check_status(0, "t2.restart", 1'b0, 1'b0, 0, NONE);
    send(0, 2, 2); send(0, 6, 1); send(0, 7, 0);
    check_status(0, "t2.end", 1'b1, 1'b0, 3, 32'd1);

    // table writes are ignored outside IDLE
    load(0, 0, 99);
    pulse_start(0);
    send(0, 2, 0); send(0, 5, 0); send(0, 7, 0);
    check_status(0, "t2b.nowrite", 1'b1, 1'b1, 3, NONE);

    // NOut=1, timeout after 8 RUN cycles
    pulse_start(1);
    repeat (7) tick();
    check("t3.before.finished", 32'(finished_s[1]), 32'd0);
    tick();
    check_status(1, "t3.timeout", 1'b1, 1'b0, 0, NONE);

    // final transfer on the expiry edge wins
    pulse_start(1);
    repeat (7) tick();
    send(1, 2, 0);
    check_status(1, "t3b.tie", 1'b1, 1'b1, 1, NONE);

    // NOut=1, good word then overflow
    pulse_start(1);
    send(1, 2, 0);
    check_status(1, "t4.good", 1'b1, 1'b1, 1, NONE);
    send(1, 9, 0);
    check_status(1, "t4.ovf", 1'b1, 1'b0, 2, NONE);

    // NOut=0 finishes immediately; extra word is overflow
    pulse_start(3);
    check("t6.ready", 32'(ready_s[3]), 32'd1);
    check_status(3, "t6.start", 1'b1, 1'b1, 0, NONE);
    send(3, 5, 0);
    check_status(3, "t6.ovf", 1'b1, 1'b0, 1, NONE);

    // NOut=4: start with a same-cycle write, then reset mid-run
    we_s[2] = 1'b1; addr_s[2] = CW'(0); wdata_s[2] = MW'(55); start_s[2] = 1'b1;
    tick();
    we_s[2] = 1'b0; start_s[2] = 1'b0;
    send(2, 55, 0); send(2, 22, 0);
    check_status(2, "t5.mid", 1'b0, 1'b0, 2, NONE);
    #2 rst_n = 1'b0;
    #1;
    check("t5.rst.ready", 32'(ready_s[2]), 32'd0);
    check_status(2, "t5.rst", 1'b0, 1'b0, 0, NONE);
    rst_n = 1'b1;
    repeat (4) tick();
    pulse_start(2);
    send(2, 55, 0); send(2, 22, 0); send(2, 33, 1); send(2, 44, 0);
    check_status(2, "t5.restart", 1'b1, 1'b1, 4, NONE);

    // randomized streams against the rule-based outcome
    for (int t = 0; t < 6; t++) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
        tbl[i] = int'($urandom_range(0, 4095));
        load(2, i, tbl[i]);
      end
      pulse_start(2);
      n   = int'($urandom_range(4, 6));
      fb  = 'hFFFF;
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (i < 4) begin
          w = ($urandom_range(0, 3) == 0) ? (tbl[i] ^ int'($urandom_range(1, 4095))) : tbl[i];
          if (w != tbl[i]) begin
            bad = 1'b1;
            if (fb == 'hFFFF) fb = i;
          end
        end else begin
          w = int'($urandom_range(0, 4095));
        end
        send(2, w, int'($urandom_range(0, 2)));
      end
      check_status(2, $sformatf("rnd%0d", t), 1'b1, (!bad && n == 4), n, 32'(fb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_channel_checker.md
# out_channel_checker

Consumes the output channel of a program-running test core one word at a time over a valid/ready handshake. Compares each word against a preloaded table of expected values and reports `finished`/`success`. It is the receiving end of the out channel: the core writes `outMem` sequentially, and this block reads and judges that stream. A step-independent timeout catches programs that never produce all their output.

## Interface
Parameters:
- `MemoryElementWidth`, 12, width of each channel word and expected value
- `NOut`, 1, number of words the program must emit (0 allowed)
- `TimeoutCycles`, 1000, RUN-state cycle budget before declaring failure (>=1)
- `CountWidth`, 16, width of counters and index outputs (must hold NOut and TimeoutCycles)

Ports:
- `clock`  input  1  single clock; all state changes on its rising edge
- `reset`  input  1  asynchronous, active-low; asserting it forces reset state immediately
- `exp_we`  input  1  write strobe for the expected-value table
- `exp_addr`  input  CountWidth  table index; writes with exp_addr >= NOut are ignored
- `exp_data`  input  MemoryElementWidth  expected value
- `start`  input  1  one-cycle pulse that begins a check
- `out_valid`  input  1  producer has a word on `out_data`
- `out_data`  input  MemoryElementWidth  channel word
- `out_ready`  output  1  checker accepts a word this cycle
- `finished`  output  1  check complete (sticky until next start/reset)
- `success`  output  1  valid when finished; 1 = all words matched, no overflow, no timeout
- `received`  output  CountWidth  words accepted since start
- `first_bad`  output  CountWidth  index of first mismatching word; all-ones if none

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: `out_ready`=0, `finished`=0, `success`=0, `received`=0, `first_bad`=all-ones, timer=0, internal bad flag=0. The expected table is not cleared by reset.
- IDLE:
  - `out_ready`=0.
  - `exp_we` writes `exp_data` to `table[exp_addr]`.
  - `start` → RUN. On entry: clear `received`, `first_bad`, bad flag, timer, `finished`, `success`.
  - If NOut=0, `start` → DONE with `success`=1.
- RUN:
  - `out_ready`=1.
  - A transfer occurs when `out_valid`&&`out_ready`.
  - On a transfer, compare `out_data` with `table[received]`. On mismatch, set the bad flag; if `first_bad` is all-ones, load it with `received`. Then increment `received`.
  - Transfer of word index NOut-1 → DONE: `finished`=1, `success`=!bad (including this word's compare).
  - The timer increments every RUN cycle. When it reaches TimeoutCycles-1 with no final transfer → DONE, `finished`=1, `success`=0.
  - `exp_we` is ignored in RUN and DONE.
  - `start` in RUN is ignored.
- DONE:
  - `out_ready` stays 1 to drain the producer.
  - Any further transfer is an overflow: `success`←0, `received` increments and saturates at all-ones.
  - `start` → RUN, with the same entry clears as from IDLE.
- Comparison is over the full MemoryElementWidth bits, unsigned equality only.

## Timing
- `out_ready` is registered. It rises the cycle after `start` is sampled and falls only on reset.
- Accept latency is 0: the word is consumed on the edge where valid&&ready.
- `received`, `first_bad`, `finished` and `success` update on that same edge and are visible the following cycle.
- If the final transfer and the timeout expiry fall on the same edge, the transfer wins: success = compare result.
- If `start` and `exp_we` occur together in IDLE, the write completes and RUN begins. The written value is used if its index has not yet been compared.
- Reset asserted mid-RUN: outputs go to reset values immediately (asynchronous), with no partial verdict. Deassertion is synchronised to `clock` before the FSM leaves IDLE.
- Throughput: one word per cycle in RUN and DONE.

## Test plan
- NOut=3, table {2,5,7}, start, then stream 2,5,7 back-to-back → `finished`=1 and `success`=1 the cycle after word 3; `received`=3; `first_bad`=all-ones.
- NOut=3, table {2,5,7}, stream 2,6,7 with idle gaps → `success`=0, `first_bad`=1, `received`=3.
- NOut=1, table {2}, start, hold `out_valid`=0 for TimeoutCycles=8 → `finished`=1 and `success`=0 after 8 RUN cycles; `received`=0.
- NOut=1, table {2}, stream 2 then 9 → `success` goes 1 and then 0 the cycle after the overflow word; `received`=2.
- NOut=4, assert `reset` low after 2 good words → all outputs read reset values in the same cycle. Restart: `start` and 4 correct words → `success`=1 with the table preserved.
- NOut=0, `start` → `finished`=1 and `success`=1 one cycle later; `out_ready`=1.
